// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: redirect/stall controls into Fetch and PC/flush status out of it.
interface fetch_pc_ctrl_if;
    logic        stall;
    logic        bj_taken;
    logic [15:0] bj_addr;
    logic        siic;
    logic        rti;
    logic        halt_req;
    logic [15:0] dec_pc_plus2;
    logic        jr_taken;
    logic [15:0] jr_addr;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] epc;
    logic        flush_ifid;
    logic        flush_idex;
    logic        in_exc;
    logic        halted;
    logic        err;
    modport master (
        output stall, bj_taken, bj_addr, siic, rti, halt_req, dec_pc_plus2, jr_taken, jr_addr,
        input  pc, pc_plus2, epc, flush_ifid, flush_idex, in_exc, halted, err
    );
    modport slave (
        input  stall, bj_taken, bj_addr, siic, rti, halt_req, dec_pc_plus2, jr_taken, jr_addr,
        output pc, pc_plus2, epc, flush_ifid, flush_idex, in_exc, halted, err
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: Fetch PC/EPC/state owner with redirect arbitration and pipeline squash generation.
module fetch_pc_ctrl #(
    parameter logic [15:0] EXC_VECTOR = 16'h0002,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input logic           clk,
    input logic           rst,
    fetch_pc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, EXC, HALT} state_t;
    state_t      state, state_nx;
    logic [15:0] pc_r, pc_nx, epc_r, epc_nx, pc_seq;
    logic        fi, fe, er, dv;
    assign pc_seq = pc_r + 16'd2;
    assign dv     = !bus.stall && state != HALT && !bus.jr_taken;
    always_comb begin
        state_nx = state;
        pc_nx    = pc_r;
        epc_nx   = epc_r;
        fi       = 1'b0;
        fe       = 1'b0;
        er       = 1'b0;
        if (state == HALT) begin
        end else if (bus.jr_taken) begin
            pc_nx = bus.jr_addr;
            fi    = 1'b1;
            fe    = 1'b1;
        end else if (dv && bus.halt_req) begin
            state_nx = HALT;
            fi       = 1'b1;
        end else if (dv && bus.siic) begin
            fi = 1'b1;
            if (state == RUN) begin
                epc_nx   = bus.dec_pc_plus2;
                pc_nx    = EXC_VECTOR;
                state_nx = EXC;
            end else begin
                state_nx = HALT;
                er       = 1'b1;
            end
        end else if (dv && bus.rti) begin
            if (state == EXC) begin
                pc_nx    = epc_r;
                state_nx = RUN;
                fi       = 1'b1;
            end else begin
                er    = 1'b1;
                pc_nx = pc_seq;
            end
        end else if (dv && bus.bj_taken) begin
            pc_nx = bus.bj_addr;
            fi    = 1'b1;
        end else if (!bus.stall) begin
            pc_nx = pc_seq;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            pc_r  <= RESET_PC;
            epc_r <= 16'h0000;
        end else begin
            state <= state_nx;
            pc_r  <= pc_nx;
            epc_r <= epc_nx;
        end
    end
    assign bus.pc         = pc_r;
    assign bus.pc_plus2   = pc_seq;
    assign bus.epc        = epc_r;
    assign bus.in_exc     = state == EXC;
    assign bus.halted     = state == HALT;
    assign bus.flush_ifid = rst & fi;
    assign bus.flush_idex = rst & fe;
    assign bus.err        = rst & er;
endmodule
